// File: rtl/cs161_mc_pkg.sv
// Shared types, encodings and decode helpers for the cs161 multi-cycle datapath.
package cs161_mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_t;

  localparam int unsigned OP_W = 6;
  localparam int unsigned IMM_W = 16;
  localparam int unsigned JTGT_W = 26;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;

  localparam logic [OP_W-1:0] FN_ADD = 6'h20;
  localparam logic [OP_W-1:0] FN_SUB = 6'h22;
  localparam logic [OP_W-1:0] FN_AND = 6'h24;
  localparam logic [OP_W-1:0] FN_OR  = 6'h25;
  localparam logic [OP_W-1:0] FN_SLT = 6'h2A;

  function automatic logic funct_supported(input logic [OP_W-1:0] fn);
    case (fn)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

  function automatic logic instr_supported(input logic [OP_W-1:0] op,
                                           input logic [OP_W-1:0] fn);
    case (op)
      OP_RTYPE:                            return funct_supported(fn);
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  // Non-R-type users of the ALU (addi, lw, sw) all need an add.
  function automatic alu_op_t alu_op_of(input logic [OP_W-1:0] op,
                                        input logic [OP_W-1:0] fn);
    if (op != OP_RTYPE) return ALU_ADD;
    case (fn)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/cs161_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port,
// synchronous clear, R0 hardwired to zero.
module cs161_regfile
  import cs161_mc_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned NUM_REGS  = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [$clog2(NUM_REGS)-1:0] raddr1,
  input  logic [$clog2(NUM_REGS)-1:0] raddr2,
  output logic [WORD_SIZE-1:0]        rdata1,
  output logic [WORD_SIZE-1:0]        rdata2,
  input  logic                        we,
  input  logic [$clog2(NUM_REGS)-1:0] waddr,
  input  logic [WORD_SIZE-1:0]        wdata
);

  logic [WORD_SIZE-1:0] regs [NUM_REGS];

  // Writes to R0 are dropped so the read mux below never sees stale data there.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/cs161_multicycle_datapath.sv
// Multi-cycle MIPS-I subset core: control FSM, holding registers and ALU,
// sharing one req/ack memory port between instruction fetch and data access.
module cs161_multicycle_datapath
  import cs161_mc_pkg::*;
#(
  parameter int unsigned          WORD_SIZE = 32,
  parameter int unsigned          NUM_REGS  = 32,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [WORD_SIZE-1:0]        mem_addr,
  output logic [WORD_SIZE-1:0]        mem_wdata,
  input  logic [WORD_SIZE-1:0]        mem_rdata,
  input  logic                        mem_ack,
  output logic [WORD_SIZE-1:0]        prog_count,
  output logic [5:0]                  instr_opcode,
  output logic                        reg_write_en,
  output logic [$clog2(NUM_REGS)-1:0] write_reg_addr,
  output logic [WORD_SIZE-1:0]        write_reg_data,
  output logic                        instr_done,
  output logic                        halted
);

  localparam int unsigned AW     = $clog2(NUM_REGS);
  localparam int unsigned INSN_W = 32;

  state_t               state;
  logic [WORD_SIZE-1:0] pc;
  logic [INSN_W-1:0]    ir;
  logic [WORD_SIZE-1:0] a;
  logic [WORD_SIZE-1:0] b;
  logic [WORD_SIZE-1:0] alu_out;
  logic [WORD_SIZE-1:0] mdr;
  logic                 halted_q;

  logic [OP_W-1:0]      op;
  logic [OP_W-1:0]      fn;
  logic [AW-1:0]        rs;
  logic [AW-1:0]        rt;
  logic [AW-1:0]        rd;
  logic [WORD_SIZE-1:0] simm;
  logic                 supported;
  alu_op_t              alu_op;
  logic [WORD_SIZE-1:0] alu_b;
  logic [WORD_SIZE-1:0] alu_result;
  logic [WORD_SIZE-1:0] rdata1;
  logic [WORD_SIZE-1:0] rdata2;

  // Instruction field decode from IR; register fields truncate to the file size.
  assign op        = ir[31:26];
  assign fn        = ir[5:0];
  assign rs        = ir[21 +: AW];
  assign rt        = ir[16 +: AW];
  assign rd        = ir[11 +: AW];
  assign simm      = {{(WORD_SIZE-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
  assign supported = instr_supported(op, fn);
  assign alu_op    = alu_op_of(op, fn);

  always_comb begin
    alu_b      = (op == OP_RTYPE) ? b : simm;
    alu_result = '0;
    case (alu_op)
      ALU_ADD: alu_result = a + alu_b;
      ALU_SUB: alu_result = a - alu_b;
      ALU_AND: alu_result = a & alu_b;
      ALU_OR:  alu_result = a | alu_b;
      ALU_SLT: alu_result = WORD_SIZE'($signed(a) < $signed(alu_b));
      default: alu_result = a + alu_b;
    endcase
  end

  cs161_regfile #(
    .WORD_SIZE(WORD_SIZE),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .raddr1(rs),
    .raddr2(rt),
    .rdata1(rdata1),
    .rdata2(rdata2),
    .we    (reg_write_en),
    .waddr (write_reg_addr),
    .wdata (write_reg_data)
  );

  // Control FSM and holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      ir       <= '0;
      a        <= '0;
      b        <= '0;
      alu_out  <= '0;
      mdr      <= '0;
      halted_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ack) begin
            ir    <= mem_rdata[INSN_W-1:0];
            pc    <= pc + WORD_SIZE'(1);
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          a     <= rdata1;
          b     <= rdata2;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (!supported) begin
            halted_q <= 1'b1;
            state    <= S_HALT;
          end else begin
            case (op)
              OP_BEQ: begin
                // pc already points past the branch, so the offset is relative to PC+1.
                if (a == b) pc <= pc + simm;
                state <= S_FETCH;
              end
              OP_J: begin
                pc    <= {pc[WORD_SIZE-1:JTGT_W], ir[JTGT_W-1:0]};
                state <= S_FETCH;
              end
              OP_LW, OP_SW: begin
                alu_out <= alu_result;
                state   <= S_MEM;
              end
              default: begin
                alu_out <= alu_result;
                state   <= S_WB;
              end
            endcase
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            if (op == OP_SW) begin
              state <= S_FETCH;
            end else begin
              mdr   <= mem_rdata;
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          state <= S_FETCH;
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

  // Memory port: driven straight from held registers so it stays stable across wait states.
  assign mem_req   = !rst && ((state == S_FETCH) || (state == S_MEM));
  assign mem_we    = mem_req && (state == S_MEM) && (op == OP_SW);
  assign mem_addr  = (state == S_MEM) ? alu_out : pc;
  assign mem_wdata = b;

  assign prog_count     = pc;
  assign instr_opcode   = ir[31:26];
  assign reg_write_en   = !rst && (state == S_WB);
  assign write_reg_addr = (op == OP_RTYPE) ? rd : rt;
  assign write_reg_data = (op == OP_LW) ? mdr : alu_out;
  assign halted         = halted_q;

  // Final cycle of each supported instruction.
  assign instr_done = !rst && ((state == S_WB) ||
                               ((state == S_MEM) && (op == OP_SW) && mem_ack) ||
                               ((state == S_EXEC) && supported &&
                                ((op == OP_BEQ) || (op == OP_J))));

endmodule

// File: tb/tb_cs161_multicycle_datapath.sv
// Bench for cs161_multicycle_datapath: ISA-level reference model, wait-state memory,
// directed programs plus a randomized program.
module tb_cs161_multicycle_datapath;

  localparam int unsigned W   = 32;
  localparam int unsigned NR  = 32;
  localparam int unsigned AW  = 5;
  localparam logic [31:0] RPC = 32'd0;
  localparam logic [31:0] HALT_INSN = 32'hFC00_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_req, mem_we, mem_ack;
  logic [W-1:0]  mem_addr, mem_wdata, mem_rdata;
  logic [W-1:0]  prog_count;
  logic [5:0]    instr_opcode;
  logic          reg_write_en;
  logic [AW-1:0] write_reg_addr;
  logic [W-1:0]  write_reg_data;
  logic          instr_done, halted;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem     [256];
  logic [31:0] img     [256];
  logic [31:0] ref_mem [256];
  logic [31:0] ref_reg [32];
  logic [31:0] ref_pc;
  logic        do_load = 1'b0;
  int          delay = 0;
  int          wait_cnt = 0;

  always #5 clk = ~clk;

  cs161_multicycle_datapath #(
    .WORD_SIZE(W),
    .NUM_REGS (NR),
    .RESET_PC (RPC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack),
    .prog_count    (prog_count),
    .instr_opcode  (instr_opcode),
    .reg_write_en  (reg_write_en),
    .write_reg_addr(write_reg_addr),
    .write_reg_data(write_reg_data),
    .instr_done    (instr_done),
    .halted        (halted)
  );

  // Memory: acks after `delay` low-ack request cycles (zero = same-cycle ack).
  assign mem_ack   = mem_req && (wait_cnt >= delay);
  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;
    if (do_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else if (mem_req && mem_ack && mem_we) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                        input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 32'd0;
  endtask

  // Hold reset, load img, then release and check the post-reset state.
  task automatic do_reset();
    rst = 1'b1;
    do_load = 1'b1;
    tick();
    do_load = 1'b0;
    chk("rst_req_gated", 32'(mem_req), 32'd0);
    tick();
    for (int i = 0; i < 256; i++) ref_mem[i] = img[i];
    for (int i = 0; i < 32; i++) ref_reg[i] = 32'd0;
    ref_pc = RPC;
    rst = 1'b0;
    #1;
    chk("rst_pc", prog_count, RPC);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_done", 32'(instr_done), 32'd0);
    chk("rst_rwe", 32'(reg_write_en), 32'd0);
    chk("rst_first_req", 32'(mem_req), 32'd1);
    chk("rst_first_addr", mem_addr, RPC);
  endtask

  // Execute one instruction in the reference model and check the DUT against it.
  task automatic step(input int d, output bit is_halt);
    logic [31:0] ins, a, b, simm, npc, addr, exp_wd, exp_sa, exp_sd;
    logic [31:0] p_addr, p_wdata, wd, sa, sd;
    logic [5:0]  op, fn;
    logic        p_we;
    int          rs, rt, rd, exp_wa, base, ntr, cyc, nw, ns, wa;
    bit          exp_w, exp_s, hlt, done, prev_stall;

    delay = d;
    #1;
    ins  = ref_mem[ref_pc[7:0]];
    op   = ins[31:26];
    fn   = ins[5:0];
    rs   = int'(ins[25:21]);
    rt   = int'(ins[20:16]);
    rd   = int'(ins[15:11]);
    a    = ref_reg[rs];
    b    = ref_reg[rt];
    simm = {{16{ins[15]}}, ins[15:0]};
    npc  = ref_pc + 32'd1;
    exp_w = 1'b0; exp_s = 1'b0; exp_wa = 0; exp_wd = '0; exp_sa = '0; exp_sd = '0;
    base = 0; ntr = 1; hlt = 1'b0;
    case (op)
      6'h00: begin
        exp_w = 1'b1; exp_wa = rd; base = 4;
        case (fn)
          6'h20:   exp_wd = a + b;
          6'h22:   exp_wd = a - b;
          6'h24:   exp_wd = a & b;
          6'h25:   exp_wd = a | b;
          6'h2A:   exp_wd = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: begin hlt = 1'b1; exp_w = 1'b0; end
        endcase
      end
      6'h08: begin exp_w = 1'b1; exp_wa = rt; exp_wd = a + simm; base = 4; end
      6'h23: begin
        addr = a + simm;
        exp_w = 1'b1; exp_wa = rt; exp_wd = ref_mem[addr[7:0]]; base = 5; ntr = 2;
      end
      6'h2B: begin exp_s = 1'b1; exp_sa = a + simm; exp_sd = b; base = 4; ntr = 2; end
      6'h04: begin base = 3; if (a == b) npc = npc + simm; end
      6'h02: begin base = 3; npc = {npc[31:26], ins[25:0]}; end
      default: hlt = 1'b1;
    endcase

    chk("fetch_req", 32'(mem_req), 32'd1);
    chk("fetch_addr", mem_addr, ref_pc);
    chk("fetch_we", 32'(mem_we), 32'd0);

    cyc = 0; nw = 0; ns = 0; wa = 0; done = 1'b0; prev_stall = 1'b0;
    p_addr = '0; p_wdata = '0; p_we = 1'b0; wd = '0; sa = '0; sd = '0;
    for (int c = 0; c < 64; c++) begin
      if (c > 0) tick();
      cyc++;
      if (prev_stall && mem_req) begin
        chk("hold_addr", mem_addr, p_addr);
        chk("hold_we", 32'(mem_we), 32'(p_we));
        chk("hold_wdata", mem_wdata, p_wdata);
      end
      prev_stall = mem_req && !mem_ack;
      p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata;
      if (reg_write_en) begin nw++; wa = int'(write_reg_addr); wd = write_reg_data; end
      if (mem_req && mem_ack && mem_we) begin ns++; sa = mem_addr; sd = mem_wdata; end
      if (instr_done) done = 1'b1;
      if (done || halted) break;
    end

    ref_pc = npc;
    if (hlt) begin
      chk("halt_seen", 32'(halted), 32'd1);
      chk("halt_cycles", 32'(cyc), 32'(4 + d));
      chk("halt_no_done", 32'(done), 32'd0);
      chk("halt_no_write", 32'(nw), 32'd0);
      is_halt = 1'b1;
    end else begin
      chk("done_seen", 32'(done), 32'd1);
      chk("cycles", 32'(cyc), 32'(base + d * ntr));
      chk("num_writes", 32'(nw), 32'(exp_w));
      if (exp_w) begin
        chk("wb_addr", 32'(wa), 32'(exp_wa));
        chk("wb_data", wd, exp_wd);
        if (exp_wa != 0) ref_reg[exp_wa] = exp_wd;
      end
      chk("num_stores", 32'(ns), 32'(exp_s));
      if (exp_s) begin
        chk("st_addr", sa, exp_sa);
        chk("st_data", sd, exp_sd);
        ref_mem[exp_sa[7:0]] = exp_sd;
      end
      is_halt = 1'b0;
      tick();
    end
  endtask

  initial begin
    bit h;
    logic [5:0] fns [5];
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2A;

    // Program A: arithmetic, store/load, jump and a self-loop branch.
    clear_img();
    img[0]    = enc_i(6'h08, 0, 1, 16'd5);
    img[1]    = enc_i(6'h08, 0, 2, 16'hFFFD);
    img[2]    = enc_r(1, 2, 3, 6'h20);
    img[3]    = enc_r(2, 1, 4, 6'h2A);
    img[4]    = enc_i(6'h2B, 0, 3, 16'd8);
    img[5]    = enc_i(6'h23, 0, 5, 16'd8);
    img[6]    = {6'h02, 26'h40};
    img[10]   = enc_i(6'h04, 1, 1, 16'hFFFF);
    img[8'h40] = enc_r(1, 2, 6, 6'h22);
    img[8'h41] = enc_r(1, 2, 7, 6'h24);
    img[8'h42] = enc_r(1, 2, 8, 6'h25);
    img[8'h43] = enc_r(1, 2, 9, 6'h2A);
    img[8'h44] = enc_r(1, 1, 0, 6'h20);
    img[8'h45] = {6'h02, 26'd10};

    do_reset();
    for (int i = 0; i < 16; i++) step(0, h);

    // Same program with three wait states on every transaction.
    do_reset();
    for (int i = 0; i < 16; i++) step(3, h);

    // Random straight-line program ending in an unsupported funct.
    clear_img();
    for (int i = 128; i < 192; i++) img[i] = $urandom;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 8))
        0, 1, 2, 3, 4: img[i] = enc_r($urandom_range(0, 7), $urandom_range(0, 7),
                                      $urandom_range(0, 7), fns[$urandom_range(0, 4)]);
        5: img[i] = enc_i(6'h08, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
        6: img[i] = enc_i(6'h23, 0, $urandom_range(0, 7), 16'(128 + $urandom_range(0, 63)));
        7: img[i] = enc_i(6'h2B, 0, $urandom_range(0, 7), 16'(128 + $urandom_range(0, 63)));
        default: img[i] = enc_i(6'h04, $urandom_range(0, 3), $urandom_range(0, 3),
                                16'($urandom_range(0, 2)));
      endcase
    end
    img[30] = enc_r(1, 2, 3, 6'h21);
    img[31] = HALT_INSN;
    img[32] = HALT_INSN;
    do_reset();
    for (int s = 0; s < 60; s++) begin
      step($urandom_range(0, 2), h);
      if (h) break;
    end

    // Unsupported opcode at PC 4: core halts and stays quiet.
    clear_img();
    for (int i = 0; i < 4; i++) img[i] = enc_i(6'h08, 1, 1, 16'd1);
    img[4] = HALT_INSN;
    do_reset();
    for (int i = 0; i < 5; i++) step(0, h);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("halt_no_req", 32'(mem_req), 32'd0);
      chk("halt_pc", prog_count, 32'd5);
      chk("halt_hold", 32'(halted), 32'd1);
    end

    // Reset while a store is stalled in MEM.
    clear_img();
    img[0] = enc_i(6'h08, 0, 1, 16'd7);
    img[1] = enc_i(6'h2B, 0, 1, 16'd200);
    img[2] = HALT_INSN;
    do_reset();
    step(0, h);
    for (int c = 0; c < 10; c++) begin
      if (mem_req && mem_we) break;
      tick();
    end
    chk("e_in_mem", 32'(mem_req && mem_we), 32'd1);
    delay = 20;
    #1;
    chk("e_stalled", 32'(mem_ack), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("e_rst_gate", 32'(mem_req), 32'd0);
    tick();
    chk("e_rst_gate2", 32'(mem_req), 32'd0);
    chk("e_no_store", mem[200], 32'd0);

    // After reset every register must read zero: store each one.
    clear_img();
    for (int k = 0; k < 32; k++) img[k] = enc_i(6'h2B, 0, k, 16'(128 + k));
    img[32] = HALT_INSN;
    do_reset();
    for (int k = 0; k < 33; k++) begin
      step(k % 2, h);
      if (h) break;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cs161_multicycle_datapath.md
# cs161_multicycle_datapath

Parametrised multi-cycle successor to the single-cycle cs161 datapath. It fetches and executes a MIPS-I subset through an internal control FSM and a single shared memory port with a req/ack handshake, so memory may insert wait states. It holds PC, IR, A/B, ALUOut and MDR holding registers, plus the register file. It exposes the same debug signals as the single-cycle datapath, plus retire and halt indications.

## Interface
- `WORD_SIZE`, 32: datapath width; must be ≥32. Instruction is `mem_rdata[31:0]`.
- `NUM_REGS`, 32: register count, power of two, 2..32. Register address = `instr` field truncated to `$clog2(NUM_REGS)` bits.
- `RESET_PC`, 0: PC value after reset (word address).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_req`  out  1  memory transaction request.
- `mem_we`  out  1  1 = store, 0 = read.
- `mem_addr`  out  WORD_SIZE  word address.
- `mem_wdata`  out  WORD_SIZE  store data.
- `mem_rdata`  in  WORD_SIZE  read data; valid when `mem_ack`=1.
- `mem_ack`  in  1  transaction completes in a cycle where `mem_req`=`mem_ack`=1.
- `prog_count`  out  WORD_SIZE  current PC register.
- `instr_opcode`  out  6  IR[31:26].
- `reg_write_en`  out  1  register file write this cycle.
- `write_reg_addr`  out  $clog2(NUM_REGS)  write address.
- `write_reg_data`  out  WORD_SIZE  write data.
- `instr_done`  out  1  one-cycle pulse in an instruction's final cycle.
- `halted`  out  1  core stopped on an unsupported instruction.

## Operation
- Supported instructions:
  - R-type (op 0), funct `add` 0x20, `sub` 0x22, `and` 0x24, `or` 0x25, `slt` 0x2A.
  - `addi` 0x08, `lw` 0x23, `sw` 0x2B, `beq` 0x04, `j` 0x02.
- Any other opcode or funct → HALT.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - Drives `mem_req`=1, `mem_we`=0, `mem_addr`=PC.
  - On ack: IR←`mem_rdata[31:0]`, PC←PC+1, go to DECODE. Otherwise hold.
- DECODE: A←R[rs], B←R[rt] → EXEC.
- EXEC:
  - R-type: ALUOut←A op B → WB.
  - `addi`: ALUOut←A+sext(imm) → WB.
  - `lw`/`sw`: ALUOut←A+sext(imm) → MEM.
  - `beq`: if A==B, PC←PC+sext(imm); → FETCH.
  - `j`: PC←{PC[W-1:26], IR[25:0]} → FETCH.
  - Unsupported: → HALT.
- MEM:
  - `mem_req`=1, `mem_addr`=ALUOut; `mem_we`=1 and `mem_wdata`=B for `sw`.
  - On ack: `sw` → FETCH; `lw` MDR←`mem_rdata` → WB.
- WB:
  - Destination is rd for R-type, rt for `addi`/`lw`.
  - Data is ALUOut, or MDR for `lw`.
  - `reg_write_en`=1 → FETCH.
- HALT: absorbing; `halted`=1; no memory requests; left only via `rst`.
- Arithmetic: modulo 2^WORD_SIZE, no overflow trap. `slt` is signed, result 1/0 zero-extended. sext = imm[15] replicated to WORD_SIZE.
- R0 reads 0 always; writes to R0 are dropped, but `reg_write_en` still pulses.
- `instr_done` pulses in the last cycle of each instruction:
  - WB cycle;
  - acked MEM cycle for `sw`;
  - EXEC cycle for `beq`/`j`.
- `instr_done` never pulses for unsupported instructions.

## Timing
- Reset:
  - PC=`RESET_PC`, state=FETCH.
  - IR, A, B, ALUOut, MDR and all registers = 0.
  - `halted`=0, `instr_done`=0, `reg_write_en`=0.
- `mem_req` is gated to 0 while `rst`=1.
- `rst` asserted in any state, including mid-wait in FETCH/MEM, aborts the instruction. The first request after reset is FETCH at `RESET_PC` in the cycle after `rst` falls.
- `mem_ack` may be combinational in the request cycle (zero wait). Each extra ack-low cycle adds one cycle.
- `mem_addr`, `mem_we` and `mem_wdata` are stable while `mem_req`=1 and ack=0.
- `mem_ack` with `mem_req`=0 is ignored.
- Zero-wait cycle counts: R-type/`addi` 4, `lw` 5, `sw` 4, `beq`/`j` 3.
- The register-file write takes effect at the end of the WB cycle. The next instruction's DECODE reads the new value; no forwarding is needed.
- PC increment and branch arithmetic wrap at 2^WORD_SIZE.

## Structure
- Package `cs161_mc_pkg`:
  - state enum;
  - opcode/funct localparams;
  - ALU-op enum (ADD, SUB, AND, OR, SLT).
- Sub-module `cs161_regfile`:
  - parameters WORD_SIZE, NUM_REGS;
  - 2 async read ports, 1 sync write port;
  - synchronous clear on `rst`;
  - R0 hardwired to 0.
- FSM, holding registers and ALU live in the top module.

## Test plan
- Zero-wait program `addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2`:
  - R3=2, `slt $4,$2,$1` → R4=1;
  - `instr_done` every 4 cycles.
- `sw $3,8($0)` then `lw $5,8($0)`:
  - write at addr 8 with data 2;
  - R5=2; `lw` takes 5 cycles.
- Ack delayed 3 cycles on fetch and on MEM:
  - request signals held stable;
  - latency grows by exactly 3 per transaction.
- `beq $1,$1,-1` at PC 10 loops to PC 10. `j 0x40` → PC 0x40. Both 3 cycles.
- Opcode 0x3F at PC 4:
  - `halted`=1 two cycles after fetch completes;
  - no further `mem_req`; PC stays 5.
- `rst` pulsed during a stalled MEM of `sw`:
  - no store completes;
  - next request is fetch at `RESET_PC`;
  - all registers read 0.
